// File: rtl/n64_poll_scheduler.sv
// n64_poll_scheduler: time-multiplexes one N64 serial transaction engine over
// NUM_PORTS controller ports. Each frame polls the enabled ports in ascending
// order, sending either get-buttons (0x01) or a pending controller reset (0xFF).
// It latches the reply words, counts consecutive failures, and flags faulted ports.
module n64_poll_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int POLL_PERIOD = 100000,
  parameter int TIMEOUT     = 4000,
  parameter int GAP         = 200,
  parameter int MAX_FAIL    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       poll_enable,
  input  logic [NUM_PORTS-1:0]       port_enable,
  input  logic [NUM_PORTS-1:0]       reset_req,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic                       eng_error,
  input  logic [31:0]                eng_rx_data,
  output logic                       eng_start,
  output logic                       eng_abort,
  output logic [7:0]                 eng_cmd,
  output logic [2:0]                 eng_port_sel,
  output logic [NUM_PORTS-1:0][31:0] button_data,
  output logic [NUM_PORTS-1:0]       data_valid,
  output logic [NUM_PORTS-1:0]       port_fault,
  output logic                       frame_overrun
);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_WAIT, S_GAP} state_t;

  state_t               state;
  logic [PW-1:0]        pcnt;
  logic [TW-1:0]        tcnt;
  logic [GW-1:0]        gcnt;
  logic [NUM_PORTS-1:0] frame_mask;
  logic [NUM_PORTS-1:0] arb_oh;
  logic [2:0]           arb_idx;
  logic [NUM_PORTS-1:0] req_q;
  logic [NUM_PORTS-1:0] req_rise;
  logic [NUM_PORTS-1:0] pending;
  logic                 tick;
  logic                 tmo;
  logic                 txn_ok;
  logic                 txn_err;
  logic                 cmd_rst;

  assign tick     = (pcnt == '0) && poll_enable;
  assign tmo      = (tcnt == TW'(TIMEOUT - 1));
  assign req_rise = reset_req & ~req_q;
  assign cmd_rst  = (eng_cmd == 8'hFF);
  // eng_done beats a coincident timeout, so the error source is chosen by eng_done
  assign txn_ok   = (state == S_WAIT) && eng_done && !eng_error;
  assign txn_err  = (state == S_WAIT) && (eng_done ? eng_error : tmo);

  // Lowest-index enabled port still waiting in this frame
  always_comb begin
    arb_idx = '0;
    arb_oh  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (frame_mask[i]) begin
        arb_idx = 3'(i);
        arb_oh  = NUM_PORTS'(1) << i;
      end
    end
  end

  // Free-running frame period counter and reset_req edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      req_q <= '0;
    end else begin
      pcnt  <= (pcnt == PW'(POLL_PERIOD - 1)) ? '0 : pcnt + 1'b1;
      req_q <= reset_req;
    end
  end

  // Frame sequencer: one port at a time, start -> wait reply/timeout -> gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      frame_mask    <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      eng_start     <= 1'b0;
      eng_abort     <= 1'b0;
      eng_cmd       <= '0;
      eng_port_sel  <= '0;
      frame_overrun <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      if (tick && state != S_IDLE) frame_overrun <= 1'b1;
      case (state)
        S_IDLE: if (tick) begin
          frame_mask <= port_enable;
          if (|port_enable) state <= S_ARB;
        end
        S_ARB: begin
          frame_mask   <= frame_mask & ~arb_oh;
          eng_port_sel <= arb_idx;
          eng_cmd      <= |(pending & arb_oh) ? 8'hFF : 8'h01;
          state        <= S_START;
        end
        S_START: if (!eng_busy) begin
          eng_start <= 1'b1;
          tcnt      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            gcnt  <= '0;
            state <= S_GAP;
          end else if (tmo) begin
            eng_abort <= 1'b1;
            gcnt      <= '0;
            state     <= S_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP - 1)) state <= (|frame_mask) ? S_ARB : S_IDLE;
          else gcnt <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic          hit;
    logic [FW-1:0] fcnt;
    logic [31:0]   btn_q;
    logic          dv_q;
    logic          flt_q;
    logic          pend_q;

    assign hit            = (eng_port_sel == 3'(i));
    assign button_data[i] = btn_q;
    assign data_valid[i]  = dv_q;
    assign port_fault[i]  = flt_q;
    assign pending[i]     = pend_q;

    // Per-port reply bookkeeping on transaction completion
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fcnt  <= '0;
        btn_q <= '0;
        dv_q  <= 1'b0;
        flt_q <= 1'b0;
      end else if (hit) begin
        if (txn_ok && !cmd_rst) begin
          btn_q <= eng_rx_data;
          dv_q  <= 1'b1;
          fcnt  <= '0;
          flt_q <= 1'b0;
        end else if (txn_ok) begin
          dv_q <= 1'b0;
          fcnt <= '0;
        end else if (txn_err && fcnt != FW'(MAX_FAIL)) begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == FW'(MAX_FAIL - 1)) begin
            flt_q <= 1'b1;
            dv_q  <= 1'b0;
          end
        end
      end
    end

    // Pending reset: a new request edge outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= 1'b0;
      else        pend_q <= req_rise[i] | (pend_q & ~(hit & txn_ok & cmd_rst));
    end
  end
endmodule
